// File: rtl/set_ram_nway.sv
// -----------------------------------------------------------------------------
// set_ram_nway
//
// Set-associative style data store: NUM_WAYS independent ways, each DEPTH
// entries of SET_WIDTH bits, all sharing one address. A write updates the
// selected entry in every way whose way_we_i bit is set. A read returns all
// ways of one entry, one cycle later.
//
// After reset, and after every flush, the block walks all DEPTH entries and
// writes zero to them. This takes exactly DEPTH cycles, and ready_o stays low
// for the whole walk. The storage itself is never reset.
//
// Optional feature, enabled by defining the macro SET_RAM_PARITY_EN:
//   - one even-parity bit is stored per way entry, computed on write;
//   - each read reports a per-way parity mismatch on parity_err_o.
// When the macro is undefined, no parity storage is built and parity_err_o
// is tied to zero.
//
// Parameters
//   NUM_WAYS   number of ways
//   SET_WIDTH  data bits per way entry
//   DEPTH      entries per way (power of two, >= 2)
//   ADDR_WIDTH derived, clog2(DEPTH)
//
// Ports
//   clk_i        clock; all logic is rising-edge
//   rst_i        synchronous, active-high reset
//   req_i        access request, taken only while ready_o = 1
//   we_i         1 = write, 0 = read
//   way_we_i     per-way write enable (writes only)
//   addr_i       entry index
//   data_i       write data, broadcast to every enabled way
//   flush_i      clear all entries of all ways (ignored while clearing)
//   ready_o      block idle and accepting requests
//   rvalid_o     one-cycle pulse qualifying rdata_o / parity_err_o
//   rdata_o      read data; way w is in bits [w*SET_WIDTH +: SET_WIDTH]
//   parity_err_o per-way parity error, valid with rvalid_o
// -----------------------------------------------------------------------------
module set_ram_nway #(
    parameter  int NUM_WAYS   = 4,
    parameter  int SET_WIDTH  = 128,
    parameter  int DEPTH      = 256,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [NUM_WAYS-1:0]           way_we_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [SET_WIDTH-1:0]          data_i,
    input  logic                          flush_i,
    output logic                          ready_o,
    output logic                          rvalid_o,
    output logic [NUM_WAYS*SET_WIDTH-1:0] rdata_o,
    output logic [NUM_WAYS-1:0]           parity_err_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  rvalid_q;

    // Access qualification. Flush beats a same-cycle request, and nothing
    // is accepted while the clear walk is running or reset is asserted.
    logic clearing;
    logic accept;
    logic wr_accept;
    logic rd_accept;

    assign clearing  = (state_q == ST_CLEAR) && !rst_i;
    assign accept    = (state_q == ST_IDLE) && req_i && !flush_i && !rst_i;
    assign wr_accept = accept && we_i;
    assign rd_accept = accept && !we_i;

    // -------------------------------------------------------------------------
    // Control FSM: CLEAR walks clr_cnt over every entry, IDLE serves requests.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of the others, whatever the block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    // flush_i is deliberately not looked at here: a flush
                    // during the walk neither restarts nor extends it.
                    if (clr_cnt_q == LAST_ENTRY) begin
                        state_q   <= ST_IDLE;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                ST_IDLE: begin
                    if (flush_i) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                    end else if (rd_accept) begin
                        rvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign rvalid_o = rvalid_q;

    // -------------------------------------------------------------------------
    // Per-way storage, read register and optional parity.
    // -------------------------------------------------------------------------
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic [SET_WIDTH-1:0]  mem_q [DEPTH];
        logic [SET_WIDTH-1:0]  rdata_q;
        logic                  wr_en;
        logic [ADDR_WIDTH-1:0] wr_addr;
        logic [SET_WIDTH-1:0]  wr_data;

        // The clear walk and normal writes share the single write port;
        // they can never collide because they live in different states.
        assign wr_en   = clearing || (wr_accept && way_we_i[w]);
        assign wr_addr = clearing ? clr_cnt_q : addr_i;
        assign wr_data = clearing ? '0 : data_i;

        // NOTE: the array has no reset branch on purpose; it stays a plain
        // RAM and is zeroed by the clear walk instead of by rst_i.
        always_ff @(posedge clk_i) begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
        end

        // Holds its value between reads.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rdata_q <= '0;
            end else if (rd_accept) begin
                rdata_q <= mem_q[addr_i];
            end
        end

        assign rdata_o[w*SET_WIDTH +: SET_WIDTH] = rdata_q;

`ifdef SET_RAM_PARITY_EN
        logic par_q [DEPTH];
        logic perr_q;

        // Even parity: stored bit makes the total count of ones even.
        // Cleared entries store 0, which matches all-zero data.
        always_ff @(posedge clk_i) begin
            if (wr_en) begin
                par_q[wr_addr] <= ^wr_data;
            end
        end

        // Only meaningful together with rvalid_o, so it drops back to zero
        // on every cycle that is not a read response.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                perr_q <= 1'b0;
            end else if (rd_accept) begin
                perr_q <= (^mem_q[addr_i]) ^ par_q[addr_i];
            end else begin
                perr_q <= 1'b0;
            end
        end

        assign parity_err_o[w] = perr_q;
`else
        assign parity_err_o[w] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_set_ram_nway.sv
// -----------------------------------------------------------------------------
// tb_set_ram_nway
//
// Self-checking bench for set_ram_nway (default parameters). A behavioural
// model (plain arrays plus a countdown of remaining clear cycles) predicts
// ready_o, rvalid_o, rdata_o and parity_err_o after every clock edge, and a
// compare process checks the DUT against it every cycle. Directed sequences
// add hand-computed literal expectations, followed by a randomized phase.
// Parity-fault injection is only built when SET_RAM_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_set_ram_nway;

    localparam int NUM_WAYS  = 4;
    localparam int SET_WIDTH = 128;
    localparam int DEPTH     = 256;
    localparam int AW        = 8;
    localparam int DW        = NUM_WAYS * SET_WIDTH;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 req_i;
    logic                 we_i;
    logic [NUM_WAYS-1:0]  way_we_i;
    logic [AW-1:0]        addr_i;
    logic [SET_WIDTH-1:0] data_i;
    logic                 flush_i;
    logic                 ready_o;
    logic                 rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic [NUM_WAYS-1:0]  parity_err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    set_ram_nway #(
        .NUM_WAYS (NUM_WAYS),
        .SET_WIDTH(SET_WIDTH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .way_we_i    (way_we_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .parity_err_o(parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: contents per way/entry, cycles of clearing left.
    // -------------------------------------------------------------------------
    logic [SET_WIDTH-1:0] model_mem [NUM_WAYS][DEPTH];
    logic                 model_bad [NUM_WAYS][DEPTH];
    int                   clear_left = DEPTH;
    logic                 exp_rvalid = 1'b0;
    logic [DW-1:0]        exp_rdata  = '0;
    logic [NUM_WAYS-1:0]  exp_perr   = '0;

    task automatic model_start_clear();
        clear_left = DEPTH;
        // Nothing can be read until the walk ends, so zero everything now.
        for (int w = 0; w < NUM_WAYS; w++)
            for (int a = 0; a < DEPTH; a++) begin
                model_mem[w][a] = '0;
                model_bad[w][a] = 1'b0;
            end
    endtask

    always @(posedge clk_i) begin
        exp_rvalid = 1'b0;
        exp_perr   = '0;
        if (rst_i) begin
            model_start_clear();
            exp_rdata = '0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (flush_i) begin
            model_start_clear();
        end else if (req_i && we_i) begin
            for (int w = 0; w < NUM_WAYS; w++)
                if (way_we_i[w]) begin
                    model_mem[w][addr_i] = data_i;
                    model_bad[w][addr_i] = 1'b0;
                end
        end else if (req_i) begin
            exp_rvalid = 1'b1;
            for (int w = 0; w < NUM_WAYS; w++) begin
                exp_rdata[w*SET_WIDTH +: SET_WIDTH] = model_mem[w][addr_i];
`ifdef SET_RAM_PARITY_EN
                exp_perr[w] = model_bad[w][addr_i];
`endif
            end
        end
        #1;
        check("model_ready",  {511'b0, ready_o},  {511'b0, (clear_left == 0)});
        check("model_rvalid", {511'b0, rvalid_o}, {511'b0, exp_rvalid});
        check("model_rdata",  rdata_o, exp_rdata);
        check("model_perr",   {508'b0, parity_err_o}, {508'b0, exp_perr});
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [3:0] m, input logic [SET_WIDTH-1:0] d);
        req_i = 1'b1; we_i = 1'b1; way_we_i = m; addr_i = a; data_i = d;
        step();
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        step();
        req_i = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int cycles = 0;
        while (!ready_o && cycles < 1000) begin
            step();
            cycles++;
        end
        check(name, DW'(cycles), DW'(256));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SET_WIDTH-1:0] a5;
        logic [DW-1:0]        exp;
        logic [SET_WIDTH-1:0] p0, pf, p8;

        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; way_we_i = '0;
        addr_i = '0; data_i = '0; flush_i = 1'b0;
        repeat (3) step();
        check("reset_ready",  {511'b0, ready_o},  '0);
        check("reset_rvalid", {511'b0, rvalid_o}, '0);
        check("reset_rdata",  rdata_o, '0);
        check("reset_perr",   {508'b0, parity_err_o}, '0);

        // Reset release: 256 cycles not ready, then a read of a cleared entry.
        rst_i = 1'b0;
        wait_ready("release_ready_cycles");
        do_read(8'h10);
        check("rd10_rvalid", {511'b0, rvalid_o}, DW'(1));
        check("rd10_rdata",  rdata_o, '0);
        step();
        check("rd10_rvalid_drop", {511'b0, rvalid_o}, '0);

        // Masked write then immediate read of the same address.
        a5 = {16{8'hA5}};
        do_write(8'h3F, 4'b0101, a5);
        check("wr_no_rvalid", {511'b0, rvalid_o}, '0);
        do_read(8'h3F);
        exp = {128'h0, a5, 128'h0, a5};
        check("masked_rvalid", {511'b0, rvalid_o}, DW'(1));
        check("masked_rdata",  rdata_o, exp);
        step();
        check("rdata_hold", rdata_o, exp);

        // Pipelined reads including the top entry.
        p0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        pf = 128'hFFFF_0000_DEAD_BEEF_1234_5678_9ABC_DEF0;
        p8 = 128'h8080_8080_1357_9BDF_2468_ACE0_5A5A_5A5A;
        do_write(8'h00, 4'hF, p0);
        do_write(8'hFF, 4'hF, pf);
        do_write(8'h80, 4'hF, p8);
        do_read(8'h00);
        check("pipe0_rvalid", {511'b0, rvalid_o}, DW'(1));
        check("pipe0_rdata",  rdata_o, {4{p0}});
        do_read(8'hFF);
        check("pipeF_rvalid", {511'b0, rvalid_o}, DW'(1));
        check("pipeF_rdata",  rdata_o, {4{pf}});
        do_read(8'h80);
        check("pipe8_rvalid", {511'b0, rvalid_o}, DW'(1));
        check("pipe8_rdata",  rdata_o, {4{p8}});
        step();
        check("pipe_end_rvalid", {511'b0, rvalid_o}, '0);

        // Parity: without the feature the flag stays zero.
        do_write(8'h05, 4'hF, p0);
`ifdef SET_RAM_PARITY_EN
        dut.g_way[1].mem_q[5][0] = ~dut.g_way[1].mem_q[5][0];
        model_mem[1][5][0] = ~model_mem[1][5][0];
        model_bad[1][5] = 1'b1;
        do_read(8'h05);
        check("parity_fault", {508'b0, parity_err_o}, DW'(4'b0010));
`else
        do_read(8'h05);
        check("parity_off", {508'b0, parity_err_o}, '0);
`endif
        check("parity_rvalid", {511'b0, rvalid_o}, DW'(1));

        // Flush and read together: flush wins.
        flush_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 8'h3F;
        step();
        flush_i = 1'b0; req_i = 1'b0;
        check("flush_no_rvalid", {511'b0, rvalid_o}, '0);
        check("flush_not_ready", {511'b0, ready_o},  '0);
        flush_i = 1'b1;  // ignored during the walk
        wait_ready("flush_ready_cycles");
        flush_i = 1'b0;
        do_read(8'h3F);
        check("flush_rd3F", rdata_o, '0);
        do_read(8'hFF);
        check("flush_rdFF", rdata_o, '0);

        // Reset in the middle of a clear restarts it.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        repeat (100) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        wait_ready("midclear_ready_cycles");

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            req_i    = ($urandom_range(0, 3) != 0);
            we_i     = $urandom_range(0, 1) == 1;
            way_we_i = 4'($urandom);
            addr_i   = 8'($urandom_range(0, 15)) | ($urandom_range(0, 7) == 0 ? 8'hF0 : 8'h00);
            data_i   = {$urandom, $urandom, $urandom, $urandom};
            flush_i  = ($urandom_range(0, 299) == 0);
            rst_i    = ($urandom_range(0, 999) == 0);
            step();
        end
        rst_i = 1'b0; req_i = 1'b0; flush_i = 1'b0;
        repeat (300) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
